field_sequencer: RTL and testbench
==================================

FIELD_SEQUENCER -- requirements
Module: field_sequencer

Interface
REQ-001 Parameter BUFFER_WIDTH, default 8, bits per pattern field.
REQ-002 Parameter BUFFER_SIZE, default 32, number of pattern fields; ADDR_W = clog2(BUFFER_SIZE).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 step  input  1  advance read pointer by one field.
REQ-006 jump  input  1  load read pointer from jump_addr.
REQ-007 jump_addr  input  ADDR_W  read pointer target.
REQ-008 wr_valid  input  1  host write request.
REQ-009 wr_ready  output  1  write accepted when wr_valid && wr_ready at posedge.
REQ-010 wr_addr  input  ADDR_W  field index to write.
REQ-011 wr_data  input  BUFFER_WIDTH  field value to write.
REQ-012 load_start  input  1  begin serial bulk load.
REQ-013 load_req  output  1  high while a serial bit is being requested.
REQ-014 load_bit_in  input  1  serial bit, valid whenever load_req is high.
REQ-015 load_done  output  1  one-cycle pulse at bulk-load completion.
REQ-016 fieldp  output  BUFFER_SIZE  one-hot read select to pattern buffer.
REQ-017 fieldwp  output  BUFFER_SIZE  one-hot write select to pattern buffer.
REQ-018 field_in  output  BUFFER_WIDTH  write data to pattern buffer.
REQ-019 field_write  output  1  write strobe to pattern buffer.
REQ-020 ssel  output  1  serial shift enable to pattern buffer.
REQ-021 sin  output  1  serial data to pattern buffer.
REQ-022 ptr_end  output  1  high while read pointer equals BUFFER_SIZE-1.

Function
REQ-023 All outputs SHALL be registered except wr_ready, which SHALL be decoded combinationally from the state register.
REQ-024 The FSM SHALL have states IDLE, WRITE, LOAD, LDONE.
REQ-025 In IDLE with load_start=1, the FSM SHALL go to LOAD and clear the 8-bit bit counter; load_start SHALL take priority over wr_valid.
REQ-026 In IDLE with wr_valid=1 and load_start=0, the FSM SHALL go to WRITE and register wr_data into field_in and the one-hot decode of wr_addr into fieldwp.
REQ-027 In WRITE, field_write SHALL be high for exactly one cycle; the FSM SHALL then return to IDLE; fieldwp and field_in SHALL hold their values until the next accepted write.
REQ-028 wr_ready SHALL be 1 only in IDLE with load_start=0, giving at most one write per two cycles.
REQ-029 In LOAD, load_req SHALL be high for exactly BUFFER_SIZE*BUFFER_WIDTH consecutive cycles (256 at defaults); the bit counter increments each cycle.
REQ-030 ssel and sin SHALL be load_req and load_bit_in delayed by one register stage, so ssel is high for exactly 256 cycles.
REQ-031 After the last load_req cycle, the FSM SHALL enter LDONE for one cycle, in which load_done SHALL be 1 (coincident with the last ssel cycle) and then return to IDLE.
REQ-032 load_start outside IDLE SHALL be ignored.
REQ-033 The read pointer SHALL update on any cycle in any state; jump SHALL take priority over step; fieldp SHALL reflect the new pointer one cycle after the request.
REQ-034 fieldp and fieldwp SHALL always be exactly one-hot.
REQ-035 jump_addr or wr_addr >= BUFFER_SIZE SHALL be reduced modulo BUFFER_SIZE.

Reset
REQ-036 On resetn=0, the block SHALL asynchronously set: state IDLE, read pointer 0 (fieldp=1), fieldwp=1, field_in=0, field_write=0, ssel=0, sin=0, load_req=0, load_done=0, bit counter 0.
REQ-037 Reset asserted during LOAD SHALL drop ssel immediately; no load_done SHALL be generated for the aborted load.

Configuration
REQ-038 With macro FIELD_PTR_WRAP_EN defined, step at pointer BUFFER_SIZE-1 SHALL wrap the pointer to 0.
REQ-039 Without FIELD_PTR_WRAP_EN, step at pointer BUFFER_SIZE-1 SHALL hold the pointer at BUFFER_SIZE-1; ptr_end behaves identically in both builds.

Verification
REQ-040 Reset release, then wr_valid with wr_addr=5, wr_data=0xA5 -> one cycle later field_write=1, fieldwp=0x00000020, field_in=0xA5; wr_ready=0 during that cycle.
REQ-041 load_start with load_bit_in alternating 1,0 -> load_req high for 256 cycles; ssel high for 256 cycles starting one cycle later; sin follows the alternating pattern; load_done pulses once on the last ssel cycle.
REQ-042 load_start and wr_valid asserted in the same IDLE cycle -> LOAD entered, no field_write; the write is accepted in the first IDLE cycle after LDONE.
REQ-043 jump to 31, then step -> fieldp=0x80000000 with ptr_end=1, then 0x00000001 (FIELD_PTR_WRAP_EN) or 0x80000000 (not defined).
REQ-044 jump_addr=3 and step in the same cycle -> fieldp=0x00000008.
REQ-045 resetn low at load cycle 100 -> ssel=0 and load_req=0 immediately; no load_done pulse; fieldp=0x00000001.

Source files
------------

// File: rtl/field_sequencer_if.sv
// Host-side bundle for field_sequencer: pointer control, field write handshake, serial bulk-load link.
interface field_sequencer_if #(
  parameter int BUFFER_WIDTH = 8,
  parameter int BUFFER_SIZE  = 32
);
  localparam int ADDR_W = $clog2(BUFFER_SIZE);

  logic                    step;
  logic                    jump;
  logic [ADDR_W-1:0]       jump_addr;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [BUFFER_WIDTH-1:0] wr_data;
  logic                    load_start;
  logic                    load_req;
  logic                    load_bit_in;
  logic                    load_done;

  modport master (
    output step, jump, jump_addr, wr_valid, wr_addr, wr_data, load_start, load_bit_in,
    input  wr_ready, load_req, load_done
  );

  modport slave (
    input  step, jump, jump_addr, wr_valid, wr_addr, wr_data, load_start, load_bit_in,
    output wr_ready, load_req, load_done
  );
endinterface

// File: rtl/field_sequencer.sv
// Pattern-buffer sequencer: read pointer, single-field writes and serial bulk load.
// Build option: define FIELD_PTR_WRAP_EN to wrap the read pointer from the last field to 0 on step.
//
// state | meaning
// IDLE  | waiting; accepts a write or a bulk-load start
// WRITE | field_write strobe cycle for an accepted write
// LOAD  | requesting one serial bit per cycle (BUFFER_SIZE*BUFFER_WIDTH cycles)
// LDONE | load_done pulse, last shifted bit reaches the buffer
module field_sequencer #(
  parameter int BUFFER_WIDTH = 8,
  parameter int BUFFER_SIZE  = 32,
  localparam int ADDR_W = $clog2(BUFFER_SIZE),
  localparam int CNT_W  = $clog2(BUFFER_SIZE * BUFFER_WIDTH)
) (
  input  logic                    clk,
  input  logic                    resetn,
  field_sequencer_if.slave        bus,
  output logic [BUFFER_SIZE-1:0]  fieldp,
  output logic [BUFFER_SIZE-1:0]  fieldwp,
  output logic [BUFFER_WIDTH-1:0] field_in,
  output logic                    field_write,
  output logic                    ssel,
  output logic                    sin,
  output logic                    ptr_end
);

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BUFFER_SIZE * BUFFER_WIDTH - 1);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(BUFFER_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WRITE, LOAD, LDONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0]       ptr, ptr_nxt;
  logic                    load_req_q, load_req_nxt;
  logic                    load_done_q, load_done_nxt;
  logic                    field_write_nxt;
  logic [BUFFER_WIDTH-1:0] field_in_nxt;
  logic [BUFFER_SIZE-1:0]  fieldwp_nxt;

  // Addresses are ADDR_W wide, so one conditional subtract is a full modulo.
  function automatic logic [ADDR_W-1:0] mod_addr(input logic [ADDR_W-1:0] a);
    int unsigned v;
    v = 32'(a);
    if (v >= BUFFER_SIZE) v = v - BUFFER_SIZE;
    return ADDR_W'(v);
  endfunction

  function automatic logic [BUFFER_SIZE-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [BUFFER_SIZE-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign bus.wr_ready  = (state == IDLE) && !bus.load_start;
  assign bus.load_req  = load_req_q;
  assign bus.load_done = load_done_q;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    load_req_nxt    = 1'b0;
    load_done_nxt   = 1'b0;
    field_write_nxt = 1'b0;
    field_in_nxt    = field_in;
    fieldwp_nxt     = fieldwp;
    case (state)
      IDLE: begin
        if (bus.load_start) begin
          state_nxt    = LOAD;
          cnt_nxt      = '0;
          load_req_nxt = 1'b1;
        end else if (bus.wr_valid) begin
          state_nxt       = WRITE;
          field_write_nxt = 1'b1;
          field_in_nxt    = bus.wr_data;
          fieldwp_nxt     = onehot(mod_addr(bus.wr_addr));
        end
      end
      WRITE: state_nxt = IDLE;
      LOAD: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST_CNT) begin
          state_nxt     = LDONE;
          load_done_nxt = 1'b1;
        end else begin
          load_req_nxt = 1'b1;
        end
      end
      LDONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt = ptr;
    if (bus.jump) begin
      ptr_nxt = mod_addr(bus.jump_addr);
    end else if (bus.step) begin
      if (ptr == LAST_PTR) begin
`ifdef FIELD_PTR_WRAP_EN
        ptr_nxt = '0;
`else
        ptr_nxt = ptr;
`endif
      end else begin
        ptr_nxt = ptr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= '0;
      fieldp      <= BUFFER_SIZE'(1);
      ptr_end     <= 1'b0;
      fieldwp     <= BUFFER_SIZE'(1);
      field_in    <= '0;
      field_write <= 1'b0;
      ssel        <= 1'b0;
      sin         <= 1'b0;
      load_req_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ptr         <= ptr_nxt;
      fieldp      <= onehot(ptr_nxt);
      ptr_end     <= (ptr_nxt == LAST_PTR);
      fieldwp     <= fieldwp_nxt;
      field_in    <= field_in_nxt;
      field_write <= field_write_nxt;
      // Serial link to the buffer trails the request by one register stage.
      ssel        <= load_req_q;
      sin         <= bus.load_bit_in;
      load_req_q  <= load_req_nxt;
      load_done_q <= load_done_nxt;
    end
  end

endmodule

// File: tb/tb_field_sequencer.sv
// Self-checking bench for field_sequencer: cycle model compare plus directed literal checks.
module tb_field_sequencer;

  localparam int SIZE  = 32;
  localparam int WIDTH = 8;
  localparam int TOTAL = SIZE * WIDTH;
`ifdef FIELD_PTR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk;
  logic resetn;
  logic [SIZE-1:0]  fieldp, fieldwp;
  logic [WIDTH-1:0] field_in;
  logic field_write, ssel, sin, ptr_end;

  field_sequencer_if #(.BUFFER_WIDTH(WIDTH), .BUFFER_SIZE(SIZE)) bus ();

  field_sequencer #(.BUFFER_WIDTH(WIDTH), .BUFFER_SIZE(SIZE)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .fieldp(fieldp), .fieldwp(fieldwp), .field_in(field_in),
    .field_write(field_write), .ssel(ssel), .sin(sin), .ptr_end(ptr_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the outputs must be, tracked as counts and indices.
  int          m_ptr;
  int          m_load_left;   // load_req cycles still to come
  bit          m_fw, m_done, m_ssel, m_sin;
  logic [31:0] m_fwp;
  logic [7:0]  m_fin;
  int          old_left;
  bit          m_idle;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ptr = 0; m_load_left = 0; m_fw = 0; m_done = 0; m_ssel = 0; m_sin = 0;
      m_fwp = 32'h1; m_fin = 8'h0;
    end else begin
      m_idle   = !m_fw && (m_load_left == 0) && !m_done;
      old_left = m_load_left;
      m_ssel   = (old_left > 0);
      m_sin    = bus.load_bit_in;
      m_done   = (old_left == 1);
      m_fw     = m_idle && !bus.load_start && bus.wr_valid;
      if (m_fw) begin
        m_fin = bus.wr_data;
        m_fwp = 32'(1) << (int'(bus.wr_addr) % SIZE);
      end
      if (m_idle && bus.load_start) m_load_left = TOTAL;
      else if (old_left > 0)        m_load_left = old_left - 1;
      if (bus.jump)
        m_ptr = int'(bus.jump_addr) % SIZE;
      else if (bus.step)
        m_ptr = (m_ptr == SIZE - 1) ? (WRAP ? 0 : SIZE - 1) : m_ptr + 1;
    end
  end

  // Event tallies for the directed literal checks.
  int cyc = 0, req_cnt = 0, ssel_cnt = 0, done_cnt = 0, done_ssel_cnt = 0;
  int sin_one_cnt = 0, fw_cnt = 0, done_cyc = 0, fw_cyc = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    chk("fieldp",      64'(fieldp),        64'(32'(1) << m_ptr));
    chk("ptr_end",     64'(ptr_end),       64'(m_ptr == SIZE - 1));
    chk("fieldwp",     64'(fieldwp),       64'(m_fwp));
    chk("field_in",    64'(field_in),      64'(m_fin));
    chk("field_write", 64'(field_write),   64'(m_fw));
    chk("load_req",    64'(bus.load_req),  64'(m_load_left > 0));
    chk("load_done",   64'(bus.load_done), 64'(m_done));
    chk("ssel",        64'(ssel),          64'(m_ssel));
    if (m_ssel) chk("sin", 64'(sin), 64'(m_sin));
    chk("wr_ready", 64'(bus.wr_ready),
        64'(!m_fw && m_load_left == 0 && !m_done && !bus.load_start));
    if (bus.load_req) req_cnt++;
    if (ssel) begin ssel_cnt++; if (sin) sin_one_cnt++; end
    if (bus.load_done) begin done_cnt++; done_cyc = cyc; if (ssel) done_ssel_cnt++; end
    if (field_write) begin fw_cnt++; fw_cyc = cyc; end
  end

  task automatic idle_inputs();
    bus.step = 0; bus.jump = 0; bus.jump_addr = '0; bus.wr_valid = 0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.load_start = 0; bus.load_bit_in = 0;
  endtask

  task automatic clear_tallies();
    req_cnt = 0; ssel_cnt = 0; done_cnt = 0; done_ssel_cnt = 0; sin_one_cnt = 0; fw_cnt = 0;
  endtask

  initial begin
    int  base_done;
    bit  seen;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base_done;
    bit  seen;
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fieldp",   64'(fieldp),      64'h1);
    chk("rst_fieldwp",  64'(fieldwp),     64'h1);
    chk("rst_field_in", 64'(field_in),    64'h0);
    chk("rst_ssel",     64'(ssel),        64'h0);
    chk("rst_load_req", 64'(bus.load_req),64'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Single write: addr 5, data 0xA5.
    bus.wr_valid = 1; bus.wr_addr = 5'd5; bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_valid = 0;
    chk("wr_strobe",  64'(field_write),  64'h1);
    chk("wr_fieldwp", 64'(fieldwp),      64'h20);
    chk("wr_data",    64'(field_in),     64'hA5);
    chk("wr_busy",    64'(bus.wr_ready), 64'h0);
    @(negedge clk);
    chk("wr_strobe_one", 64'(field_write), 64'h0);
    chk("wr_hold",       64'(fieldwp),     64'h20);

    // Held wr_valid: at most one write per two cycles.
    clear_tallies();
    bus.wr_valid = 1; bus.wr_addr = 5'd31; bus.wr_data = 8'h3C;
    repeat (6) @(negedge clk);
    bus.wr_valid = 0;
    @(negedge clk);
    chk("wr_rate", 64'(fw_cnt), 64'd3);
    chk("wr_last_fieldwp", 64'(fieldwp), 64'h80000000);

    // Bulk load with alternating bits; a stray load_start mid-load is ignored.
    clear_tallies();
    bus.load_bit_in = 0; bus.load_start = 1;
    for (int i = 0; i < TOTAL + 6; i++) begin
      @(negedge clk);
      bus.load_start  = (i == 50);
      bus.load_bit_in = ~i[0];
    end
    chk("load_req_cycles",  64'(req_cnt),       64'd256);
    chk("ssel_cycles",      64'(ssel_cnt),      64'd256);
    chk("sin_ones",         64'(sin_one_cnt),   64'd128);
    chk("load_done_pulses", 64'(done_cnt),      64'd1);
    chk("done_on_ssel",     64'(done_ssel_cnt), 64'd1);
    bus.load_bit_in = 0;

    // load_start and wr_valid together: load wins, write follows LDONE.
    clear_tallies();
    bus.load_start = 1; bus.wr_valid = 1; bus.wr_addr = 5'd7; bus.wr_data = 8'h5A;
    @(negedge clk);
    bus.load_start = 0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (field_write) seen = 1;
    end
    bus.wr_valid = 0;
    chk("pri_write_seen", 64'(seen),     64'h1);
    chk("pri_done",       64'(done_cnt), 64'd1);
    chk("pri_fw_after",   64'(fw_cyc - done_cyc), 64'd2);
    chk("pri_fieldwp",    64'(fieldwp),  64'h80);
    repeat (2) @(negedge clk);
    chk("pri_fw_count",   64'(fw_cnt),   64'd1);

    // Pointer end behaviour.
    bus.jump = 1; bus.jump_addr = 5'd31;
    @(negedge clk);
    bus.jump = 0; bus.step = 1;
    chk("jump31_fieldp",  64'(fieldp),  64'h80000000);
    chk("jump31_ptr_end", 64'(ptr_end), 64'h1);
    @(negedge clk);
    bus.step = 0;
    chk("end_step_fieldp", 64'(fieldp), WRAP ? 64'h1 : 64'h80000000);
    chk("end_step_ptr_end", 64'(ptr_end), WRAP ? 64'h0 : 64'h1);

    // jump beats step.
    bus.jump = 1; bus.jump_addr = 5'd3; bus.step = 1;
    @(negedge clk);
    bus.jump = 0;
    chk("jump_prio", 64'(fieldp), 64'h8);
    repeat (3) @(negedge clk);
    bus.step = 0;
    chk("step_run", 64'(fieldp), 64'h40);

    // Reset in the middle of a load.
    clear_tallies();
    bus.load_start = 1;
    @(negedge clk);
    bus.load_start = 0;
    repeat (99) @(negedge clk);
    chk("abort_mid_load", 64'(bus.load_req), 64'h1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_ssel",     64'(ssel),         64'h0);
    chk("abort_load_req", 64'(bus.load_req), 64'h0);
    chk("abort_fieldp",   64'(fieldp),       64'h1);
    base_done = done_cnt;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (300) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(base_done));
    chk("abort_no_done_zero", 64'(done_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
